// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch-redirect bus between the pipeline control and pc_gen.
//   stall[STALL_W]      pipeline stall vector; only bit 0 is used by pc_gen
//   flush               flush redirect request
//   flush_target        flush redirect address
//   branch_flag_i       branch taken from ID
//   branch_target_i     branch target from ID
//   pc                  registered fetch address
//   ce                  registered instruction-memory chip enable
//   redirect_pending    a captured branch is waiting for stall release
//   misalign            one-cycle pulse after a misaligned redirect
// master: pipeline side (drives requests); slave: pc_gen side.
interface pc_gen_if #(
    parameter int ADDR_W  = 32,
    parameter int STALL_W = 6
);
    logic [STALL_W-1:0] stall;
    logic               flush;
    logic [ADDR_W-1:0]  flush_target;
    logic               branch_flag_i;
    logic [ADDR_W-1:0]  branch_target_i;
    logic [ADDR_W-1:0]  pc;
    logic               ce;
    logic               redirect_pending;
    logic               misalign;

    modport master (
        output stall, flush, flush_target, branch_flag_i, branch_target_i,
        input  pc, ce, redirect_pending, misalign
    );

    modport slave (
        input  stall, flush, flush_target, branch_flag_i, branch_target_i,
        output pc, ce, redirect_pending, misalign
    );
endinterface

// File: rtl/pc_gen.sv
// pc_gen: program-counter generator for the fetch stage.
//   clk   clock, all state updates on rising edge
//   rst   synchronous active-high reset
//   bus   pc_gen_if.slave: stall/flush/branch requests in, pc/ce/
//         redirect_pending/misalign out (all outputs registered)
// Per-edge priority in RUN: flush > stall[0] > branch > pending > sequential.
// Branches arriving during a fetch stall are parked and applied on release.
module pc_gen #(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter int                STEP         = 4,
    parameter int                STALL_W      = 6
) (
    input logic   clk,
    input logic   rst,
    pc_gen_if.slave bus
);
    typedef enum logic {OFF, RUN} state_t;

    // Low address bits that must be zero for an aligned fetch.
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(STEP - 1);
    localparam logic [ADDR_W-1:0] STEP_A   = ADDR_W'(STEP);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
    logic              mis_q, mis_d;

    logic              redir;
    logic [ADDR_W-1:0] redir_tgt;

    // Only the fetch-stall bit matters here; the rest of the vector is ignored.
    logic stall_unused;
    assign stall_unused = ^bus.stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= OFF;
            pc_q       <= RESET_VECTOR;
            pend_q     <= 1'b0;
            pend_tgt_q <= '0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
            mis_q      <= mis_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
        mis_d      = 1'b0;
        redir      = 1'b0;
        redir_tgt  = '0;

        case (state_q)
            OFF: begin
                state_d = RUN;
                pc_d    = RESET_VECTOR;
                pend_d  = 1'b0;
            end
            RUN: begin
                if (bus.flush) begin
                    redir     = 1'b1;
                    redir_tgt = bus.flush_target;
                    pend_d    = 1'b0;
                end else if (bus.stall[0]) begin
                    // Hold pc; a branch seen now is parked, newest wins.
                    if (bus.branch_flag_i) begin
                        pend_d     = 1'b1;
                        pend_tgt_d = bus.branch_target_i;
                    end
                end else if (bus.branch_flag_i) begin
                    redir     = 1'b1;
                    redir_tgt = bus.branch_target_i;
                    pend_d    = 1'b0;
                end else if (pend_q) begin
                    redir     = 1'b1;
                    redir_tgt = pend_tgt_q;
                    pend_d    = 1'b0;
                end else begin
                    pc_d = pc_q + STEP_A;
                end

                // Misalignment is judged only when a target is actually applied.
                if (redir) begin
                    pc_d  = redir_tgt & ~LOW_MASK;
                    mis_d = |(redir_tgt & LOW_MASK);
                end
            end
            default: state_d = OFF;
        endcase
    end

    assign bus.pc               = pc_q;
    assign bus.ce               = (state_q == RUN);
    assign bus.redirect_pending = pend_q;
    assign bus.misalign         = mis_q;
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed vector table plus randomized run for pc_gen.
// Two instances share one stimulus stream: RESET_VECTOR 0 and 0xBFC00000.
// Both are checked every cycle against a behavioural model; the default
// instance is additionally checked against the fixed vector table.
module tb_pc_gen;
    localparam int AW = 32;
    localparam int SW = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst      = 1'b1;
    logic [SW-1:0] s_stall  = '0;
    logic          s_flush  = 1'b0;
    logic [AW-1:0] s_ft     = '0;
    logic          s_br     = 1'b0;
    logic [AW-1:0] s_bt     = '0;

    pc_gen_if #(.ADDR_W(AW), .STALL_W(SW)) if0 ();
    pc_gen_if #(.ADDR_W(AW), .STALL_W(SW)) if1 ();

    assign if0.stall           = s_stall;
    assign if0.flush           = s_flush;
    assign if0.flush_target    = s_ft;
    assign if0.branch_flag_i   = s_br;
    assign if0.branch_target_i = s_bt;
    assign if1.stall           = s_stall;
    assign if1.flush           = s_flush;
    assign if1.flush_target    = s_ft;
    assign if1.branch_flag_i   = s_br;
    assign if1.branch_target_i = s_bt;

    pc_gen #(.ADDR_W(AW), .STEP(4), .STALL_W(SW)) dut0 (
        .clk(clk), .rst(rst), .bus(if0.slave)
    );
    pc_gen #(.ADDR_W(AW), .RESET_VECTOR(32'hBFC0_0000), .STEP(4), .STALL_W(SW)) dut1 (
        .clk(clk), .rst(rst), .bus(if1.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: expected fetch address and a parked branch per instance.
    bit            m_on  [2];
    logic [AW-1:0] m_pc  [2];
    bit            m_pv  [2];
    logic [AW-1:0] m_pt  [2];
    bit            m_mis [2];
    logic [AW-1:0] m_rv  [2];

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            bit do_redir;
            longint unsigned t;
            do_redir = 0;
            t = 0;
            if (rst) begin
                m_on[k] = 0; m_pc[k] = m_rv[k]; m_pv[k] = 0; m_pt[k] = '0; m_mis[k] = 0;
            end else if (!m_on[k]) begin
                m_on[k] = 1; m_pc[k] = m_rv[k]; m_pv[k] = 0; m_mis[k] = 0;
            end else begin
                m_mis[k] = 0;
                if (s_flush) begin
                    t = s_ft; do_redir = 1; m_pv[k] = 0;
                end else if (s_stall[0]) begin
                    if (s_br) begin m_pv[k] = 1; m_pt[k] = s_bt; end
                end else if (s_br) begin
                    t = s_bt; do_redir = 1; m_pv[k] = 0;
                end else if (m_pv[k]) begin
                    t = m_pt[k]; do_redir = 1; m_pv[k] = 0;
                end else begin
                    m_pc[k] = AW'((longint'(m_pc[k]) + 4) % 64'h1_0000_0000);
                end
                if (do_redir) begin
                    m_pc[k]  = AW'((t / 4) * 4);
                    m_mis[k] = (t % 4) != 0;
                end
            end
        end
    endtask

    task automatic step(input bit r, input logic [SW-1:0] st, input bit fl,
                        input logic [AW-1:0] ft, input bit br, input logic [AW-1:0] bt);
        @(negedge clk);
        rst = r; s_stall = st; s_flush = fl; s_ft = ft; s_br = br; s_bt = bt;
        @(posedge clk);
        model_edge();
        #1;
        check("d0.pc",  if0.pc, m_pc[0]);
        check("d0.ce",  AW'(if0.ce), AW'(m_on[0]));
        check("d0.rp",  AW'(if0.redirect_pending), AW'(m_pv[0]));
        check("d0.mis", AW'(if0.misalign), AW'(m_mis[0]));
        check("d1.pc",  if1.pc, m_pc[1]);
        check("d1.ce",  AW'(if1.ce), AW'(m_on[1]));
        check("d1.rp",  AW'(if1.redirect_pending), AW'(m_pv[1]));
        check("d1.mis", AW'(if1.misalign), AW'(m_mis[1]));
    endtask

    typedef struct {
        bit            rst;
        bit            stall;
        bit            flush;
        logic [AW-1:0] ft;
        bit            br;
        logic [AW-1:0] bt;
        logic [AW-1:0] pc;
        bit            ce;
        bit            rp;
        bit            mis;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit r, bit st, bit fl, logic [AW-1:0] ft, bit br,
                                logic [AW-1:0] bt, logic [AW-1:0] pc, bit ce, bit rp, bit mis);
        vec_t v;
        v.rst = r; v.stall = st; v.flush = fl; v.ft = ft; v.br = br; v.bt = bt;
        v.pc = pc; v.ce = ce; v.rp = rp; v.mis = mis;
        return v;
    endfunction

    initial begin
        m_rv[0] = 32'h0000_0000;
        m_rv[1] = 32'hBFC0_0000;
        for (int k = 0; k < 2; k++) begin
            m_on[k] = 0; m_pc[k] = m_rv[k]; m_pv[k] = 0; m_pt[k] = '0; m_mis[k] = 0;
        end

        //                rst st fl ft            br bt            pc            ce rp mis
        tbl.push_back(mk(1, 0, 0, 0,            0, 0,            32'h0,        0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0,            0, 0,            32'h0,        0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0,            0, 0,            32'h0,        0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0,            32'h0,        1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0,            32'h4,        1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0,            32'h8,        1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0,            32'hC,        1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0,            32'h10,       1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,            1, 32'h100,      32'h100,      1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0,            32'h104,      1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,            1, 32'h200,      32'h104,      1, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0,            0, 0,            32'h104,      1, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0,            0, 0,            32'h104,      1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0,            32'h200,      1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0,            32'h204,      1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,            1, 32'h200,      32'h204,      1, 1, 0));
        tbl.push_back(mk(0, 1, 1, 32'h80,       0, 0,            32'h80,       1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,            0, 0,            32'h80,       1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0,            32'h84,       1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,            1, 32'h400,      32'h84,       1, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0,            1, 32'h500,      32'h84,       1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0,            32'h500,      1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,            1, 32'h600,      32'h500,      1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,            1, 32'h700,      32'h700,      1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0,            32'h704,      1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,            1, 32'h302,      32'h300,      1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0,            32'h304,      1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,            1, 32'h413,      32'h304,      1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0,            32'h410,      1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0,            32'h414,      1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 32'h81,       0, 0,            32'h80,       1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 32'hFFFFFFFC, 0, 0,            32'hFFFFFFFC, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0,            32'h0,        1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,            1, 32'h900,      32'h0,        1, 1, 0));
        tbl.push_back(mk(1, 1, 0, 0,            1, 32'hA00,      32'h0,        0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0,            32'h0,        1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0,            32'h4,        1, 0, 0));

        foreach (tbl[i]) begin
            step(tbl[i].rst, SW'(tbl[i].stall), tbl[i].flush, tbl[i].ft, tbl[i].br, tbl[i].bt);
            check($sformatf("tbl%0d.pc", i),  if0.pc, tbl[i].pc);
            check($sformatf("tbl%0d.ce", i),  AW'(if0.ce), AW'(tbl[i].ce));
            check($sformatf("tbl%0d.rp", i),  AW'(if0.redirect_pending), AW'(tbl[i].rp));
            check($sformatf("tbl%0d.mis", i), AW'(if0.misalign), AW'(tbl[i].mis));
        end

        // Randomized traffic; upper stall bits are junk the design must ignore.
        for (int n = 0; n < 3000; n++) begin
            bit            r, fl, br;
            logic [SW-1:0] st;
            logic [AW-1:0] ft, bt;
            r  = ($urandom_range(0, 63) == 0);
            st = SW'($urandom);
            st[0] = ($urandom_range(0, 2) == 0);
            fl = ($urandom_range(0, 15) == 0);
            br = ($urandom_range(0, 3) == 0);
            ft = $urandom;
            bt = $urandom;
            if ($urandom_range(0, 1) == 0) ft[1:0] = 2'b00;
            if ($urandom_range(0, 1) == 0) bt[1:0] = 2'b00;
            if ($urandom_range(0, 31) == 0) ft = 32'hFFFF_FFF8;
            step(r, st, fl, ft, br, bt);
        end

        // Mid-run reset on the 0xBFC00000 instance with a parked branch.
        step(1, '0, 0, 0, 0, 0);
        step(0, '0, 0, 0, 0, 0);
        step(0, '0, 0, 0, 0, 0);
        check("rv.run.pc", if1.pc, 32'hBFC0_0004);
        step(0, 6'b000001, 0, 0, 1, 32'h0000_1234);
        check("rv.pend.rp", AW'(if1.redirect_pending), 32'd1);
        step(1, 6'b000001, 0, 0, 1, 32'h0000_5678);
        check("rv.rst.pc", if1.pc, 32'hBFC0_0000);
        check("rv.rst.ce", AW'(if1.ce), 32'd0);
        check("rv.rst.rp", AW'(if1.redirect_pending), 32'd0);
        step(0, '0, 0, 0, 0, 0);
        check("rv.up.pc", if1.pc, 32'hBFC0_0000);
        check("rv.up.ce", AW'(if1.ce), 32'd1);
        step(0, '0, 0, 0, 0, 0);
        check("rv.seq.pc", if1.pc, 32'hBFC0_0004);
        check("rv.seq.rp", AW'(if1.redirect_pending), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, PC/target width in bits.
REQ-002 SHALL have parameter RESET_VECTOR, default 0, PC value while fetch disabled.
REQ-003 SHALL have parameter STEP, default 4, sequential increment; power of two, ≥1.
REQ-004 SHALL have parameter STALL_W, default 6, pipeline stall vector width.
REQ-005 SHALL have port clk, input, 1, clock; all state updates on rising edge.
REQ-006 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-007 SHALL have port stall, input, STALL_W; only bit 0 (fetch stall) is used by this block.
REQ-008 SHALL have port flush, input, 1, exception/flush redirect request.
REQ-009 SHALL have port flush_target, input, ADDR_W, flush redirect address.
REQ-010 SHALL have port branch_flag_i, input, 1, branch-taken from ID.
REQ-011 SHALL have port branch_target_i, input, ADDR_W, branch target from ID.
REQ-012 SHALL have port pc, output, ADDR_W, registered fetch address.
REQ-013 SHALL have port ce, output, 1, registered instruction-memory chip enable.
REQ-014 SHALL have port redirect_pending, output, 1, registered; a captured branch awaits stall release.
REQ-015 SHALL have port misalign, output, 1, registered one-cycle pulse on misaligned redirect.

Function
REQ-016 SHALL implement states OFF (ce=0) and RUN (ce=1); OFF->RUN on first edge with rst=0; any state->OFF on edge with rst=1.
REQ-017 SHALL hold pc=RESET_VECTOR, redirect_pending=0, misalign=0 on every edge where ce=0 (first RUN cycle fetches RESET_VECTOR).
REQ-018 SHALL, in RUN, apply per-edge priority: flush > stall[0] > branch_flag_i > pending redirect > sequential.
REQ-019 SHALL on flush=1 load pc<=flush_target and clear pending, regardless of stall[0] or branch_flag_i.
REQ-020 SHALL on stall[0]=1 (no flush) hold pc; if branch_flag_i=1, capture branch_target_i into pending register and set redirect_pending=1.
REQ-021 SHALL, on a second capture while redirect_pending=1, overwrite pending target (newest wins).
REQ-022 SHALL on stall[0]=0, branch_flag_i=1 load pc<=branch_target_i and clear pending (live branch beats stale pending).
REQ-023 SHALL on stall[0]=0, branch_flag_i=0, redirect_pending=1 load pc<=pending target and clear redirect_pending same edge.
REQ-024 SHALL otherwise load pc<=pc+STEP, truncated to ADDR_W (wrap all-ones region to 0).
REQ-025 SHALL, for any applied redirect (flush, branch, pending), clear low log2(STEP) bits of target before loading pc.
REQ-026 SHALL assert misalign for exactly the cycle after an applied redirect whose target had any nonzero low log2(STEP) bit; else misalign=0.
REQ-027 SHALL not flag misalign at capture time, only when the redirect is applied to pc.
REQ-028 SHALL have 1-cycle latency from any input to pc/ce/redirect_pending/misalign; no combinational input-to-output path.

Reset
REQ-029 SHALL, on edge with rst=1, set ce=0, pc=RESET_VECTOR, redirect_pending=0, misalign=0, pending target=0, regardless of other inputs.
REQ-030 SHALL discard in-flight pending redirect on mid-operation reset; after rst falls, restart from RESET_VECTOR with ce rising one edge later.

Verification
REQ-031 SHALL cover: rst 3 cycles then low, defaults -> ce 0 then 1; pc 0,0,4,8,0xC.
REQ-032 SHALL cover: at pc=0x10 branch_flag_i=1, target 0x100, stall=0 -> next pc=0x100, then 0x104.
REQ-033 SHALL cover: stall[0]=1 for 3 cycles, branch 0x200 in cycle 1 -> pc held, redirect_pending=1; after release pc=0x200, redirect_pending=0.
REQ-034 SHALL cover: stall[0]=1, pending=0x200, flush=1 target 0x80 -> pc=0x80, redirect_pending=0, next cycle pc held (still stalled).
REQ-035 SHALL cover: branch target 0x302 -> pc=0x300, misalign=1 one cycle; pc=0xFFFFFFFC sequential -> pc=0x0, misalign=0.
REQ-036 SHALL cover: RESET_VECTOR=0xBFC00000, rst asserted mid-run with redirect_pending=1 -> pc=0xBFC00000, ce=0, pending cleared.
